// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared definitions for the FFT framing/config controller.
// Holds the config-word field layout, the controller state encoding and the
// helpers that derive the scale schedule and clamp the requested point size.
package fft_ctrl_pkg;

  localparam int CFG_W     = 24;
  localparam int LOG2N_LSB = 0;
  localparam int LOG2N_W   = 4;
  localparam int FWD_BIT   = 8;
  localparam int SCALE_LSB = 9;
  localparam int SCALE_W   = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CFG    = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Conservative per-stage scaling, one 2-bit field per radix-2 stage pair.
  function automatic logic [SCALE_W-1:0] scale_sch(input logic [LOG2N_W-1:0] log2n);
    logic [SCALE_W-1:0] s;
    case (log2n)
      4'd0, 4'd1, 4'd2, 4'd3: s = 12'd6;
      4'd4:  s = 12'd10;
      4'd5:  s = 12'd26;
      4'd6:  s = 12'd42;
      4'd7:  s = 12'd106;
      4'd8:  s = 12'd170;
      4'd9:  s = 12'd426;
      4'd10: s = 12'd682;
      4'd11: s = 12'd1706;
      default: s = 12'd2730;
    endcase
    return s;
  endfunction

  function automatic logic [LOG2N_W-1:0] clamp_log2n(input logic [LOG2N_W-1:0] v,
                                                     input logic [LOG2N_W-1:0] max_v);
    logic [LOG2N_W-1:0] r;
    if (v < 4'd3)
      r = 4'd3;
    else if (v > max_v)
      r = max_v;
    else
      r = v;
    return r;
  endfunction

endpackage

// File: rtl/fft_cfg_gen.sv
// fft_cfg_gen: shadow config registers, pending flag and the FFT config word
// register with its valid/ready handshake.
// Ports: cfg_* request inputs, load (controller entering CFG), cfg_tdata/
// cfg_tvalid/cfg_tready to the core, cfg_hs and pend_any back to the FSM.
module fft_cfg_gen
  import fft_ctrl_pkg::*;
#(
  parameter int MAX_LOG2N = 12,
  parameter int DEF_LOG2N = 9,
  parameter int DEF_FWD   = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        cfg_log2n,
  input  logic              cfg_fwd,
  input  logic              cfg_update,
  input  logic              load,
  input  logic              cfg_tready,
  output logic [CFG_W-1:0]  cfg_tdata,
  output logic              cfg_tvalid,
  output logic              cfg_hs,
  output logic              pend_any
);

  logic [LOG2N_W-1:0] log2n_q;
  logic               fwd_q;
  logic               pending_q;
  logic [LOG2N_W-1:0] req_log2n;
  logic [LOG2N_W-1:0] nxt_log2n;
  logic               nxt_fwd;

  assign req_log2n = clamp_log2n(cfg_log2n, LOG2N_W'(MAX_LOG2N));

  // A request arriving on the same edge as the load must be the one issued,
  // so the word is built from the shadow registers' next values.
  assign nxt_log2n = cfg_update ? req_log2n : log2n_q;
  assign nxt_fwd   = cfg_update ? cfg_fwd   : fwd_q;

  assign cfg_hs   = cfg_tvalid & cfg_tready;
  assign pend_any = pending_q | cfg_update;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      log2n_q    <= LOG2N_W'(DEF_LOG2N);
      fwd_q      <= 1'(DEF_FWD);
      pending_q  <= 1'b1;
      cfg_tdata  <= '0;
      cfg_tvalid <= 1'b0;
    end else begin
      if (cfg_update) begin
        log2n_q <= req_log2n;
        fwd_q   <= cfg_fwd;
      end

      // An update coinciding with the handshake keeps pending set so the
      // new values go out at the next frame boundary.
      if (cfg_update)
        pending_q <= 1'b1;
      else if (cfg_hs)
        pending_q <= 1'b0;

      if (load) begin
        cfg_tdata  <= {3'b000, scale_sch(nxt_log2n), nxt_fwd, 4'b0000, nxt_log2n};
        cfg_tvalid <= 1'b1;
      end else if (cfg_hs) begin
        cfg_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: cuts an unframed sample stream into 2^log2n frames with
// tlast and issues the FFT config word before the first frame and after changes.
// Ports: cfg_* requests, s_axis_* samples in, m_axis_config_*/m_axis_data_* to
// the core, frame_cnt/busy status; FFT_CTRL_ERR_CNT_EN adds event inputs + err_cnt.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_LOG2N = 12,
  parameter int DEF_LOG2N = 9,
  parameter int DEF_FWD   = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        cfg_log2n,
  input  logic              cfg_fwd,
  input  logic              cfg_update,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [23:0]       m_axis_config_tdata,
  output logic              m_axis_config_tvalid,
  input  logic              m_axis_config_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              m_axis_data_tlast,
  output logic [15:0]       frame_cnt,
`ifdef FFT_CTRL_ERR_CNT_EN
  input  logic              event_tlast_unexpected,
  input  logic              event_tlast_missing,
  output logic [15:0]       err_cnt,
`endif
  output logic              busy
);

  localparam int CW = MAX_LOG2N;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [LOG2N_W-1:0] nlog_q;
  logic [CW:0]        frame_len;
  logic [CW-1:0]      last_idx;
  logic               is_last;
  logic               data_hs;
  logic               load;
  logic               cfg_hs;
  logic               pend_any;

  fft_cfg_gen #(
    .MAX_LOG2N (MAX_LOG2N),
    .DEF_LOG2N (DEF_LOG2N),
    .DEF_FWD   (DEF_FWD)
  ) u_cfg_gen (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_log2n  (cfg_log2n),
    .cfg_fwd    (cfg_fwd),
    .cfg_update (cfg_update),
    .load       (load),
    .cfg_tready (m_axis_config_tready),
    .cfg_tdata  (m_axis_config_tdata),
    .cfg_tvalid (m_axis_config_tvalid),
    .cfg_hs     (cfg_hs),
    .pend_any   (pend_any)
  );

  assign frame_len = (CW+1)'(1) << nlog_q;
  assign last_idx  = CW'(frame_len - (CW+1)'(1));
  assign is_last   = (cnt_q == last_idx);
  assign data_hs   = (state_q == STREAM) & s_axis_tvalid & m_axis_data_tready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d            = state_q;
    load               = 1'b0;
    s_axis_tready      = 1'b0;
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tdata  = '0;
    m_axis_data_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_any) begin
          state_d = CFG;
          load    = 1'b1;
        end
      end
      CFG: begin
        if (cfg_hs)
          state_d = STREAM;
      end
      STREAM: begin
        s_axis_tready      = m_axis_data_tready;
        m_axis_data_tvalid = s_axis_tvalid;
        m_axis_data_tdata  = s_axis_tdata;
        m_axis_data_tlast  = is_last;
        // Frames run back to back unless a new config must go out first.
        if (data_hs && is_last && pend_any) begin
          state_d = CFG;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nlog_q    <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_hs) begin
        // Frame length follows the word the core actually accepted.
        nlog_q <= m_axis_config_tdata[LOG2N_LSB +: LOG2N_W];
        cnt_q  <= '0;
      end else if (data_hs) begin
        if (is_last) begin
          cnt_q     <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

`ifdef FFT_CTRL_ERR_CNT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn)
      err_cnt <= '0;
    else if ((event_tlast_unexpected | event_tlast_missing) && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed table-driven bench for fft_frame_ctrl.
// Each table row is one frame: expected config word, frame length, gaps, and
// an optional cfg_update injected at a given sample index.
module tb_fft_frame_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  cfg_log2n;
  logic        cfg_fwd;
  logic        cfg_update;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [23:0] m_axis_config_tdata;
  logic        m_axis_config_tvalid;
  logic        m_axis_config_tready;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready;
  logic        m_axis_data_tlast;
  logic [15:0] frame_cnt;
  logic        busy;
`ifdef FFT_CTRL_ERR_CNT_EN
  logic        event_tlast_unexpected;
  logic        event_tlast_missing;
  logic [15:0] err_cnt;
`endif

  always #5 aclk = ~aclk;

  fft_frame_ctrl dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .cfg_log2n            (cfg_log2n),
    .cfg_fwd              (cfg_fwd),
    .cfg_update           (cfg_update),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .m_axis_config_tdata  (m_axis_config_tdata),
    .m_axis_config_tvalid (m_axis_config_tvalid),
    .m_axis_config_tready (m_axis_config_tready),
    .m_axis_data_tdata    (m_axis_data_tdata),
    .m_axis_data_tvalid   (m_axis_data_tvalid),
    .m_axis_data_tready   (m_axis_data_tready),
    .m_axis_data_tlast    (m_axis_data_tlast),
    .frame_cnt            (frame_cnt),
`ifdef FFT_CTRL_ERR_CNT_EN
    .event_tlast_unexpected (event_tlast_unexpected),
    .event_tlast_missing    (event_tlast_missing),
    .err_cnt                (err_cnt),
`endif
    .busy                 (busy)
  );

  typedef struct {
    bit          has_cfg;
    logic [23:0] word;
    int          len;
    int          hold;
    bit          gaps;
    int          upd_idx;
    logic [3:0]  upd_l;
    logic        upd_f;
  } row_t;

  row_t        tbl[8];
  int          tests = 0;
  int          fails = 0;
  int unsigned seq = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Returns 1 ns after the rising edge; inputs are driven there, outputs sampled 1 ns later.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_cfg(input logic [23:0] exp_word, input int hold, input bit upd,
                          input logic [3:0] ul, input logic uf, output int n);
    n = 0;
    m_axis_config_tready = 1'b0;
    s_axis_tvalid        = 1'b1;
    m_axis_data_tready   = 1'b1;
    #1;
    while (!m_axis_config_tvalid && n < 50) begin
      step();
      #1;
      n++;
    end
    check("cfg_tvalid", 32'(m_axis_config_tvalid), 32'd1);
    check("cfg_word", 32'(m_axis_config_tdata), 32'(exp_word));
    check("cfg_blocks_samples", 32'({s_axis_tready, m_axis_data_tvalid}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      #1;
      check("cfg_hold_word", 32'(m_axis_config_tdata), 32'(exp_word));
      check("cfg_hold_vld", 32'(m_axis_config_tvalid), 32'd1);
    end
    m_axis_config_tready = 1'b1;
    if (upd) begin
      cfg_update = 1'b1;
      cfg_log2n  = ul;
      cfg_fwd    = uf;
    end
    step();
    m_axis_config_tready = 1'b0;
    cfg_update           = 1'b0;
    s_axis_tvalid        = 1'b0;
  endtask

  task automatic send_frame(input int len, input int nsend, input bit gaps,
                            input int upd_idx, input logic [3:0] ul, input logic uf);
    int idx = 0;
    int cyc = 0;
    bit done_upd = 0;
    bit exp_hs;
    while (idx < nsend && cyc < 20000) begin
      s_axis_tvalid      = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_data_tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata       = seq;
      cfg_update         = 1'b0;
      if (!done_upd && idx == upd_idx) begin
        cfg_update = 1'b1;
        cfg_log2n  = ul;
        cfg_fwd    = uf;
        done_upd   = 1;
      end
      #1;
      exp_hs = s_axis_tvalid && m_axis_data_tready;
      check("data_hs", 32'(m_axis_data_tvalid && s_axis_tready), 32'(exp_hs));
      if (exp_hs) begin
        check("data_pass", m_axis_data_tdata, seq);
        check("tlast", 32'(m_axis_data_tlast), 32'(idx == len - 1));
      end
      step();
      cyc++;
      if (exp_hs) begin
        idx++;
        seq++;
      end
    end
    cfg_update    = 1'b0;
    s_axis_tvalid = 1'b0;
    check("frame_samples", 32'(idx), 32'(nsend));
  endtask

  task automatic check_reset_outputs();
    check("rst_cfg_vld", 32'(m_axis_config_tvalid), 32'd0);
    check("rst_cfg_word", 32'(m_axis_config_tdata), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_data_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_data_tlast), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 24'h035509,  512, 0, 0,  100,  4'd9, 1'b0};
    tbl[1] = '{1, 24'h035409,  512, 0, 0,  511,  4'd4, 1'b1};
    tbl[2] = '{1, 24'h001504,   16, 0, 0,    5,  4'd1, 1'b1};
    tbl[3] = '{1, 24'h000D03,    8, 0, 0,    2, 4'd15, 1'b1};
    tbl[4] = '{1, 24'h15550C, 4096, 0, 0, 4095,  4'd9, 1'b1};
    tbl[5] = '{1, 24'h035509,  512, 5, 1,   -1,  4'd0, 1'b0};
    tbl[6] = '{0, 24'h000000,  512, 0, 1,   -1,  4'd0, 1'b0};
    tbl[7] = '{0, 24'h000000,  512, 0, 1,   -1,  4'd0, 1'b0};

    aresetn              = 1'b0;
    cfg_log2n            = 4'd0;
    cfg_fwd              = 1'b0;
    cfg_update           = 1'b0;
    s_axis_tdata         = 32'd0;
    s_axis_tvalid        = 1'b1;
    m_axis_config_tready = 1'b0;
    m_axis_data_tready   = 1'b1;
`ifdef FFT_CTRL_ERR_CNT_EN
    event_tlast_unexpected = 1'b0;
    event_tlast_missing    = 1'b0;
`endif
    repeat (3) step();
    #1;
    check_reset_outputs();
`ifdef FFT_CTRL_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

    aresetn = 1'b1;
    step();
    check("busy_after_release", 32'(busy), 32'd1);

    for (int r = 0; r < 8; r++) begin
      if (tbl[r].has_cfg) begin
        wait_cfg(tbl[r].word, tbl[r].hold, 0, 4'd0, 1'b0, n);
        if (r == 0)
          check("cfg_first_latency", 32'(n), 32'd0);
      end else begin
        check("no_bubble_cfg_vld", 32'(m_axis_config_tvalid), 32'd0);
      end
      send_frame(tbl[r].len, tbl[r].len, tbl[r].gaps, tbl[r].upd_idx, tbl[r].upd_l, tbl[r].upd_f);
      check("frame_cnt", 32'(frame_cnt), 32'(r + 1));
    end

    // Abandon a frame at sample 200 with a mid-stream reset.
    send_frame(512, 200, 0, -1, 4'd0, 1'b0);
    aresetn            = 1'b0;
    s_axis_tvalid      = 1'b1;
    m_axis_data_tready = 1'b1;
    step();
    #1;
    check_reset_outputs();
    aresetn = 1'b1;
    step();

    // Update coinciding with the config handshake forces one more config word.
    wait_cfg(24'h035509, 0, 1, 4'd9, 1'b1, n);
    check("cfg_after_reset_latency", 32'(n), 32'd0);
    send_frame(512, 512, 0, -1, 4'd0, 1'b0);
    check("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);
    wait_cfg(24'h035509, 0, 0, 4'd0, 1'b0, n);
    check("repeat_cfg_latency", 32'(n), 32'd0);
    check("frame_cnt_unchanged", 32'(frame_cnt), 32'd1);

`ifdef FFT_CTRL_ERR_CNT_EN
    event_tlast_missing = 1'b1;
    repeat (3) step();
    event_tlast_missing = 1'b0;
    step();
    #1;
    check("err_cnt", 32'(err_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
